// File: rtl/alarme_carro_pkg.sv
// Shared types and constants for the car-alarm controller.
// No logic; pure declarations.
// No flow control; consumed by alarme_carro and its bench.
package alarme_carro_pkg;

    // FSM state encoding; the value 2'd3 is unused and recovers to DISARMED.
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        ALARM    = 2'd2
    } state_t;

    // 0 = alarm never times out, only the remote clears it.
    localparam int DEFAULT_ALARM_TIMEOUT = 0;
    localparam int DEFAULT_TIMER_W       = 16;

endpackage : alarme_carro_pkg

// File: rtl/alarme_carro_rise_detect.sv
// Registered 0->1 edge detector producing a one-cycle pulse per rising level.
// Latency: pulse is combinational from din and the one-cycle-old history.
// No backpressure; history resets to 1 so a level already high at reset release is not an edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_q;
    logic din_d;

    // Next history value is simply the current input level.
    always_comb begin
        din_d = din;
    end

    // History register; reset to 1 to suppress a false edge at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b1;
        end else begin
            din_q <= din_d;
        end
    end

    assign pulse = din & ~din_q;

endmodule : rise_detect

// File: rtl/alarme_carro.sv
// Car-alarm FSM: remote press toggles armed state or silences alarm; sensor fires alarm when armed.
// Latency: state and registered alarm output change at the first clk edge after the triggering input.
// No backpressure; inputs are levels sampled every cycle.
module alarme_carro
    import alarme_carro_pkg::*;
#(
    parameter int ALARM_TIMEOUT = DEFAULT_ALARM_TIMEOUT,
    parameter int TIMER_W       = DEFAULT_TIMER_W
) (
    input  logic clk,
    input  logic rst,
    input  logic remote,
    input  logic sensor,
    output logic alarm
);

    // Counter value on the last cycle of the alarm before auto-return to ARMED.
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST =
        (ALARM_TIMEOUT == 0) ? '0 : TIMER_W'(ALARM_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (ALARM_TIMEOUT != 0);

    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;
    logic               alarm_q;
    logic               alarm_d;
    logic               press;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst_n (rst),
        .din   (remote),
        .pulse (press)
    );

    // Next-state, timeout counter and Moore output decode; press always has priority.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DISARMED: begin
                if (press) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (press) begin
                    state_d = DISARMED;
                end else if (sensor) begin
                    state_d = ALARM;
                    cnt_d   = '0;
                end
            end
            ALARM: begin
                if (press) begin
                    state_d = DISARMED;
                end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
                    state_d = ARMED;
                end else begin
                    cnt_d = cnt_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = DISARMED;
            end
        endcase
        // Registering the decode of the next state keeps alarm aligned with the state change.
        alarm_d = (state_d == ALARM);
    end

    // State, counter and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DISARMED;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;

endmodule : alarme_carro

// File: tb/tb_alarme_carro.sv
// Directed bench for alarme_carro: one instance with no timeout, one with a 4-cycle timeout.
// Outputs are sampled 1 ns after the rising edge; inputs are driven at the same point.
// Each comparison is an immediate assertion that counts and reports mismatches.
module tb_alarme_carro;
    import alarme_carro_pkg::*;

    logic clk;
    logic rst;
    logic remote;
    logic sensor;
    logic alarm;
    logic remote4;
    logic sensor4;
    logic alarm4;

    int checks;
    int errors;

    alarme_carro #(.ALARM_TIMEOUT(0), .TIMER_W(16)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .remote (remote),
        .sensor (sensor),
        .alarm  (alarm)
    );

    alarme_carro #(.ALARM_TIMEOUT(4), .TIMER_W(16)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .remote (remote4),
        .sensor (sensor4),
        .alarm  (alarm4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold remote high for 8 cycles, expecting exactly one transition to exp_state.
    task automatic press8(input string tag, input logic [1:0] exp_state);
        remote = 1'b1;
        tick();
        check({tag, "_first_edge"}, dut0.state_q, exp_state);
        for (int i = 0; i < 7; i++) begin
            tick();
            check({tag, "_held"}, dut0.state_q, exp_state);
            check({tag, "_alarm"}, {1'b0, alarm}, 2'd0);
        end
        remote = 1'b0;
        tick();
        check({tag, "_release"}, dut0.state_q, exp_state);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        remote  = 1'b0;
        sensor  = 1'b0;
        remote4 = 1'b0;
        sensor4 = 1'b0;

        // Reset held for 50 ns.
        #20;
        check("reset_alarm", {1'b0, alarm}, 2'd0);
        check("reset_state", dut0.state_q, DISARMED);
        #30;
        rst = 1'b1;
        tick();
        check("post_reset_alarm", {1'b0, alarm}, 2'd0);
        check("post_reset_state", dut0.state_q, DISARMED);

        // Arm / disarm / arm with long presses.
        press8("arm1", ARMED);
        press8("disarm1", DISARMED);
        press8("arm2", ARMED);

        // Sensor pulse of 2 cycles while armed: alarm latches.
        sensor = 1'b1;
        tick();
        check("sensor_alarm_on", {1'b0, alarm}, 2'd1);
        check("sensor_state_alarm", dut0.state_q, ALARM);
        tick();
        sensor = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("alarm_latched", {1'b0, alarm}, 2'd1);
        end

        // Remote press silences the alarm.
        remote = 1'b1;
        tick();
        check("silence_alarm", {1'b0, alarm}, 2'd0);
        check("silence_state", dut0.state_q, DISARMED);
        remote = 1'b0;
        tick();

        // Sensor ignored while disarmed.
        sensor = 1'b1;
        tick();
        tick();
        sensor = 1'b0;
        check("disarmed_sensor_alarm", {1'b0, alarm}, 2'd0);
        check("disarmed_sensor_state", dut0.state_q, DISARMED);

        // Press and sensor together while armed: press wins.
        press8("arm3", ARMED);
        remote = 1'b1;
        sensor = 1'b1;
        tick();
        check("tie_state", dut0.state_q, DISARMED);
        check("tie_alarm", {1'b0, alarm}, 2'd0);
        remote = 1'b0;
        sensor = 1'b0;
        tick();
        check("tie_after", dut0.state_q, DISARMED);

        // Timeout instance: arm, then a 1-cycle sensor pulse gives exactly 4 alarm cycles.
        remote4 = 1'b1;
        tick();
        check("t4_armed", dut4.state_q, ARMED);
        remote4 = 1'b0;
        tick();
        sensor4 = 1'b1;
        tick();
        sensor4 = 1'b0;
        check("t4_alarm_c1", {1'b0, alarm4}, 2'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_alarm_hold", {1'b0, alarm4}, 2'd1);
        end
        tick();
        check("t4_alarm_off", {1'b0, alarm4}, 2'd0);
        check("t4_back_armed", dut4.state_q, ARMED);
        tick();
        check("t4_stays_armed", dut4.state_q, ARMED);

        // Remote held high across reset release must not arm.
        rst    = 1'b0;
        #2;
        remote = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("held_rel_state", dut0.state_q, DISARMED);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_rel_hold", dut0.state_q, DISARMED);
        end
        remote = 1'b0;
        tick();
        check("held_rel_drop", dut0.state_q, DISARMED);

        // Asynchronous reset while in ALARM.
        remote = 1'b1;
        tick();
        remote = 1'b0;
        check("arm4", dut0.state_q, ARMED);
        sensor = 1'b1;
        tick();
        sensor = 1'b0;
        check("pre_arst_alarm", {1'b0, alarm}, 2'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_alarm", {1'b0, alarm}, 2'd0);
        check("arst_state", dut0.state_q, DISARMED);
        #1;
        rst = 1'b1;
        tick();
        check("arst_after", dut0.state_q, DISARMED);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alarme_carro
